// File: rtl/bpb_pkg.sv
// Shared types and helpers for the branch-predictor pattern history table.
package bpb_pkg;

  localparam int unsigned CTR_MAX_WIDTH = 8;

  // Widest supported counter; users cast down to their own CTR_WIDTH.
  typedef logic [CTR_MAX_WIDTH-1:0] ctr_t;

  typedef enum logic {PHT_INIT, PHT_RUN} pht_state_e;

  function automatic ctr_t ctr_max(input int unsigned width);
    return ctr_t'((1 << width) - 1);
  endfunction

  function automatic ctr_t weak_nt(input int unsigned width);
    return ctr_t'((1 << (width - 1)) - 1);
  endfunction

  // Callers pass the PC and zero-extended history, then keep the low SIZE_WIDTH bits.
  function automatic logic [31:0] pht_index(input logic [31:0] pc,
                                            input logic [31:0] hist,
                                            input logic        gshare);
    return gshare ? (pc ^ hist) : pc;
  endfunction

endpackage

// File: rtl/gshare_pht_sat_counter.sv
// Combinational N-bit saturating up/down counter step.
module sat_counter
  import bpb_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] prev_i,
  input  logic                 taken_i,
  output logic [CTR_WIDTH-1:0] next_o
);

  localparam logic [CTR_WIDTH-1:0] CTR_TOP = CTR_WIDTH'(ctr_max(CTR_WIDTH));

  always_comb begin
    next_o = prev_i;
    if (taken_i) begin
      if (prev_i != CTR_TOP) next_o = prev_i + 1'b1;
    end else begin
      if (prev_i != '0) next_o = prev_i - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Pattern history table of saturating counters with optional gshare indexing,
// speculative GHR with mispredict recovery, and a post-reset init sweep.
module gshare_pht
  import bpb_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH  = 4,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned HIST_WIDTH  = SIZE_WIDTH,
  parameter int unsigned GSHARE      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [INDEX_WIDTH-1:0] lookup_index_i,
  input  logic                   predict_en_i,
  output logic [CTR_WIDTH-1:0]   state_o,
  output logic                   taken_o,
  output logic [HIST_WIDTH-1:0]  ghr_o,
  output logic                   ready_o,
  input  logic                   update_en_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic [HIST_WIDTH-1:0]  update_ghr_i,
  input  logic                   update_taken_i,
  input  logic                   mispredict_i
);

  localparam int unsigned           SIZE    = 2 ** SIZE_WIDTH;
  localparam logic [CTR_WIDTH-1:0]  WEAK_NT = CTR_WIDTH'(weak_nt(CTR_WIDTH));
  localparam logic [SIZE_WIDTH-1:0] LAST    = SIZE_WIDTH'(SIZE - 1);
  localparam logic                  USE_GHR = (GSHARE != 0);

  pht_state_e              state_q, state_d;
  logic [SIZE_WIDTH-1:0]   sweep_q, sweep_d;
  logic [HIST_WIDTH-1:0]   ghr_q, ghr_d;
  logic [CTR_WIDTH-1:0]    pht_q [SIZE];

  logic                    run;
  logic                    upd_we;
  logic [SIZE_WIDTH-1:0]   lk_idx, up_idx;
  logic [CTR_WIDTH-1:0]    up_cur, up_next, rd_val;

  assign run    = (state_q == PHT_RUN);
  assign upd_we = run & update_en_i;

  assign lk_idx = SIZE_WIDTH'(pht_index(32'(lookup_index_i), 32'(ghr_q), USE_GHR));
  assign up_idx = SIZE_WIDTH'(pht_index(32'(update_index_i), 32'(update_ghr_i), USE_GHR));

  assign up_cur = pht_q[up_idx];

  sat_counter #(.CTR_WIDTH(CTR_WIDTH)) u_sat (
    .prev_i  (up_cur),
    .taken_i (update_taken_i),
    .next_o  (up_next)
  );

  // Same-cycle write-to-read bypass so the fetch stage sees the resolving update.
  assign rd_val  = (upd_we && (up_idx == lk_idx)) ? up_next : pht_q[lk_idx];
  assign state_o = run ? rd_val : WEAK_NT;
  assign taken_o = state_o[CTR_WIDTH-1];
  assign ghr_o   = ghr_q;
  assign ready_o = run;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    if (!run) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST) state_d = PHT_RUN;
    end else if (mispredict_i) begin
      ghr_d = HIST_WIDTH'({update_ghr_i, update_taken_i});
    end else if (en_i && predict_en_i) begin
      ghr_d = HIST_WIDTH'({ghr_q, taken_o});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PHT_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Storage carries no reset; the sweep initialises it one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (!run) begin
      pht_q[sweep_q] <= WEAK_NT;
    end else if (update_en_i) begin
      pht_q[up_idx] <= up_next;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed table-driven bench for gshare_pht (16 entries, 2-bit counters, 4-bit GHR).
module tb_gshare_pht;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, pe, ue, ut, mp;
  logic [5:0] lpc, upc;
  logic [3:0] ughr;

  logic [1:0] st, st0;
  logic       tk, tk0, rdy, rdy0;
  logic [3:0] ghr, ghr0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gshare_pht #(.SIZE_WIDTH(4), .INDEX_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(4), .GSHARE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .lookup_index_i(lpc), .predict_en_i(pe),
    .state_o(st), .taken_o(tk), .ghr_o(ghr), .ready_o(rdy),
    .update_en_i(ue), .update_index_i(upc), .update_ghr_i(ughr),
    .update_taken_i(ut), .mispredict_i(mp));

  gshare_pht #(.SIZE_WIDTH(4), .INDEX_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(4), .GSHARE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .lookup_index_i(lpc), .predict_en_i(pe),
    .state_o(st0), .taken_o(tk0), .ghr_o(ghr0), .ready_o(rdy0),
    .update_en_i(ue), .update_index_i(upc), .update_ghr_i(ughr),
    .update_taken_i(ut), .mispredict_i(mp));

  typedef struct {
    logic [5:0] lpc;
    logic       ue;
    logic [5:0] upc;
    logic [3:0] ughr;
    logic       ut;
    logic       pe;
    logic       en;
    logic       mp;
    logic [1:0] est;
    logic [3:0] eghr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] l, input logic u, input logic [5:0] up,
                              input logic [3:0] ug, input logic t, input logic p,
                              input logic e, input logic m, input logic [1:0] es,
                              input logic [3:0] eg);
    vec_t v;
    v.lpc = l; v.ue = u; v.upc = up; v.ughr = ug; v.ut = t;
    v.pe = p; v.en = e; v.mp = m; v.est = es; v.eghr = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; pe = 1'b0; ue = 1'b0; ut = 1'b0; mp = 1'b0;
    lpc = '0; upc = '0; ughr = '0;
  endtask

  initial begin
    // Rows: lookup pc, update (en,pc,ghr,taken), predict_en, en, mispredict, expected state/ghr before the edge.
    // Counter walk on entry 5 (bypass shows post-update value in the update cycle)
    tbl.push_back(mk(6'd5, 0, 6'd0, 4'h0, 0, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b10, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b11, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b11, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 0, 2'b10, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 0, 2'b00, 4'h0));
    tbl.push_back(mk(6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 0, 2'b00, 4'h0));
    tbl.push_back(mk(6'd5, 0, 6'd0, 4'h0, 0, 0, 1, 0, 2'b00, 4'h0));
    // Bypass on entry 3
    tbl.push_back(mk(6'd3, 1, 6'd3, 4'h0, 1, 0, 1, 0, 2'b10, 4'h0));
    tbl.push_back(mk(6'd3, 0, 6'd0, 4'h0, 0, 0, 1, 0, 2'b10, 4'h0));
    // Program entries 5=11, 1=11, 2=00 while looking up untouched entry 0
    tbl.push_back(mk(6'd0, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd0, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd0, 1, 6'd5, 4'h0, 1, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd0, 1, 6'd1, 4'h0, 1, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd0, 1, 6'd1, 4'h0, 1, 0, 1, 0, 2'b01, 4'h0));
    tbl.push_back(mk(6'd0, 1, 6'd2, 4'h0, 0, 0, 1, 0, 2'b01, 4'h0));
    // Speculative history: idx 1 (T), 3^1=2 (NT), 7^2=5 (T)
    tbl.push_back(mk(6'd1, 0, 6'd0, 4'h0, 0, 1, 1, 0, 2'b11, 4'h0));
    tbl.push_back(mk(6'd3, 0, 6'd0, 4'h0, 0, 1, 1, 0, 2'b00, 4'h1));
    tbl.push_back(mk(6'd7, 0, 6'd0, 4'h0, 0, 1, 1, 0, 2'b11, 4'h2));
    // Stall: en=0 holds history; idx 7^5=2
    tbl.push_back(mk(6'd7, 0, 6'd0, 4'h0, 0, 1, 0, 0, 2'b00, 4'h5));
    // pc 6 with ghr 0101 reads entry 3
    tbl.push_back(mk(6'd6, 0, 6'd0, 4'h0, 0, 0, 1, 0, 2'b10, 4'h5));
    // Shift in a taken (idx 5) -> 1011, then mispredict overrides a concurrent shift
    tbl.push_back(mk(6'd0, 0, 6'd0, 4'h0, 0, 1, 1, 0, 2'b11, 4'h5));
    tbl.push_back(mk(6'd0, 0, 6'd0, 4'h2, 1, 1, 1, 1, 2'b01, 4'hB));
    tbl.push_back(mk(6'd0, 0, 6'd0, 4'h0, 0, 0, 1, 0, 2'b11, 4'h5));

    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_ready", rdy, 0);
    chk("reset_ghr", ghr, 0);
    chk("reset_state", st, 2'b01);
    chk("reset_taken", tk, 0);

    // Init sweep with all control inputs active; they must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    ue = 1'b1; upc = 6'd15; ughr = 4'hF; ut = 1'b1; mp = 1'b1; pe = 1'b1; lpc = 6'd9;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("init_ready_%0d", k), rdy, (k == 16) ? 1 : 0);
      if (k < 16) begin
        chk($sformatf("init_state_%0d", k), st, 2'b01);
        chk($sformatf("init_ghr_%0d", k), ghr, 0);
      end
    end
    chk("init_done_ghr", ghr, 0);
    idle();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lpc = 6'(i);
      #1;
      chk($sformatf("sweep_state_%0d", i), st, 2'b01);
      chk($sformatf("sweep_taken_%0d", i), tk, 0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      lpc = tbl[i].lpc; ue = tbl[i].ue; upc = tbl[i].upc; ughr = tbl[i].ughr;
      ut = tbl[i].ut; pe = tbl[i].pe; en = tbl[i].en; mp = tbl[i].mp;
      #1;
      chk($sformatf("row%0d_state", i), st, tbl[i].est);
      chk($sformatf("row%0d_taken", i), tk, tbl[i].est[1]);
      chk($sformatf("row%0d_ghr", i), ghr, tbl[i].eghr);
      chk($sformatf("row%0d_ready", i), rdy, 1);
    end
    @(negedge clk);
    idle();

    // Asynchronous reset while running with a non-zero GHR.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ready", rdy, 0);
    chk("async_ghr", ghr, 0);

    // Reset mid-sweep restarts from entry 0.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midsweep_ready", rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("resweep_ready_%0d", k), rdy, (k == 16) ? 1 : 0);
    end

    // GSHARE=0 instance: ghr 1111 must not disturb the pc-only index.
    @(negedge clk);
    ue = 1'b1; upc = 6'd2; ughr = 4'h0; ut = 1'b1;
    @(negedge clk);
    ue = 1'b0; mp = 1'b1; ughr = 4'h7; ut = 1'b1;
    @(negedge clk);
    idle();
    lpc = 6'd2;
    #1;
    chk("pc_only_ghr", ghr0, 4'hF);
    chk("pc_only_state", st0, 2'b10);
    chk("pc_only_taken", tk0, 1);
    chk("gshare_ghr", ghr, 4'hF);
    chk("gshare_state", st, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
